// File: rtl/instr_fetch_unit.sv
// Purpose: returns the instruction at pc, from a one-entry last-fetch buffer or from instruction memory.
// Latency: buffer hit -> fetch_done 1 cycle after the request edge; miss -> 1 cycle after the ack edge.
// Backpressure: fetch_req is accepted only in IDLE; memory stalls are bounded by TIMEOUT cycles, then fetch_err.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   fetch_req, pc, flush        control-unit request, address, buffer invalidate
//   next_instr, fetch_done,     fetched word (held), completion pulse,
//   fetch_err, busy             timeout flag (held until next accepted request), not-IDLE
//   imem_req, imem_addr,        instruction memory handshake towards memory
//   imem_ack, imem_rdata        memory response
module instr_fetch_unit #(
  parameter int ADDR_WIDTH  = 4,
  parameter int INSTR_WIDTH = 8,
  parameter int TIMEOUT     = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_req,
  input  logic [ADDR_WIDTH-1:0]  pc,
  input  logic                   flush,
  output logic [INSTR_WIDTH-1:0] next_instr,
  output logic                   fetch_done,
  output logic                   fetch_err,
  output logic                   busy,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata
);

  typedef enum logic [2:0] {IDLE, HIT, MEM, DONE, ERR} state_t;

  // Last value the counter may hold while still waiting; one more silent cycle aborts.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                 state, state_nxt;
  logic [7:0]             cnt;
  logic                   buf_vld;
  logic [ADDR_WIDTH-1:0]  buf_tag;
  logic [INSTR_WIDTH-1:0] buf_dat;
  logic                   flush_pending;

  // Decoded events for the current cycle
  logic accept, hit, ack_take, time_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    hit       = 1'b0;
    ack_take  = 1'b0;
    time_out  = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_req) begin
          accept = 1'b1;
          // A flush in the same cycle forces a fresh memory read.
          if (buf_vld && (buf_tag == pc) && !flush) begin
            hit       = 1'b1;
            state_nxt = HIT;
          end else begin
            state_nxt = MEM;
          end
        end
      end
      MEM: begin
        // Ack takes priority over the abort on the final allowed cycle.
        if (imem_ack) begin
          ack_take  = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          time_out  = 1'b1;
          state_nxt = ERR;
        end
      end
      HIT, DONE, ERR: state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  assign fetch_done = (state == HIT) || (state == DONE) || (state == ERR);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_instr    <= '0;
      fetch_err     <= 1'b0;
      imem_req      <= 1'b0;
      imem_addr     <= '0;
      cnt           <= '0;
      buf_vld       <= 1'b0;
      buf_tag       <= '0;
      buf_dat       <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (accept) begin
        imem_addr <= pc;
        fetch_err <= 1'b0;
        cnt       <= '0;
        imem_req  <= !hit;
        // Hit data is loaded on the request edge so it is valid alongside fetch_done.
        if (hit) next_instr <= buf_dat;
      end

      if ((state == MEM) && !ack_take && !time_out) cnt <= cnt + 8'd1;

      if (ack_take) begin
        next_instr <= imem_rdata;
        buf_tag    <= imem_addr;
        buf_dat    <= imem_rdata;
        imem_req   <= 1'b0;
      end

      if (time_out) begin
        imem_req  <= 1'b0;
        fetch_err <= 1'b1;
      end

      // A flush seen at any point of the access keeps the returned word out of the buffer.
      if (flush)                            buf_vld <= 1'b0;
      else if (ack_take && !flush_pending)  buf_vld <= 1'b1;

      if (state_nxt == IDLE)                flush_pending <= 1'b0;
      else if ((state == MEM) && flush)     flush_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Purpose: directed test of instr_fetch_unit with a scoreboard of expected fetch results.
// Latency: stimulus drives 1 time unit after posedge; all comparisons run at negedge in the monitor.
// Backpressure: the stimulus waits for busy to fall (bounded) before issuing the next request.
module tb_instr_fetch_unit;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       fetch_req;
  logic [3:0] pc;
  logic       flush;
  logic [7:0] next_instr;
  logic       fetch_done;
  logic       fetch_err;
  logic       busy;
  logic       imem_req;
  logic [3:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_rdata;

  instr_fetch_unit #(.ADDR_WIDTH(4), .INSTR_WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc(pc), .flush(flush),
    .next_instr(next_instr), .fetch_done(fetch_done), .fetch_err(fetch_err),
    .busy(busy), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] instr;
    logic       err;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  exp_t exp_q[$];
  chk_t chk_q[$];

  int errors = 0;
  int checks = 0;

  // ---------------- monitor: the only process that counts comparisons ----------------
  logic prev_done = 1'b0;
  exp_t e;
  chk_t c;

  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      checks++;
      if (c.act !== c.exp) begin
        errors++;
        $display("FAIL %s: actual=%0h required=%0h", c.name, c.act, c.exp);
      end
    end
    if (!reset) begin
      prev_done = 1'b0;
    end else begin
      if (fetch_done) begin
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_twice: fetch_done high two cycles in a row");
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: fetch_done=1 with no fetch outstanding");
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (next_instr !== e.instr) begin
            errors++;
            $display("FAIL next_instr: actual=%0h required=%0h", next_instr, e.instr);
          end
          checks++;
          if (fetch_err !== e.err) begin
            errors++;
            $display("FAIL fetch_err: actual=%0b required=%0b", fetch_err, e.err);
          end
        end
      end
      prev_done = fetch_done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_t t;
    t.name = name;
    t.act  = act;
    t.exp  = exp;
    chk_q.push_back(t);
  endtask

  task automatic push_exp(input logic [7:0] instr, input logic err);
    exp_t t;
    t.instr = instr;
    t.err   = err;
    exp_q.push_back(t);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    chk("idle_wait", 32'(busy), 32'd0);
  endtask

  // Miss path. ack_after = number of imem_req-high cycles before ack (0: never ack).
  // d is the returned word, or for a timeout the word next_instr must still hold.
  task automatic mem_fetch(input logic [3:0] a, input int ack_after, input logic [7:0] d,
                           input int flush_at, input int pulse_at);
    int n;
    int exp_high;
    exp_high = (ack_after == 0) ? TIMEOUT : ack_after;
    fetch_req = 1'b1;
    pc        = a;
    push_exp(d, ack_after == 0);
    @(posedge clk); #1;
    fetch_req = 1'b0;
    chk("miss_req", 32'(imem_req), 32'd1);
    chk("miss_addr", 32'(imem_addr), 32'(a));
    n = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == flush_at) flush = 1'b1;
      if (cyc == pulse_at) begin
        fetch_req = 1'b1;
        pc        = a ^ 4'h3;
      end
      if (cyc == ack_after) begin
        imem_ack   = 1'b1;
        imem_rdata = d;
      end
      @(posedge clk); #1;
      flush     = 1'b0;
      fetch_req = 1'b0;
      imem_ack  = 1'b0;
      n = cyc;
      if (!imem_req) break;
      chk("addr_stable", 32'(imem_addr), 32'(a));
    end
    chk("req_cycles", 32'(n), 32'(exp_high));
    wait_idle();
  endtask

  task automatic hit_fetch(input logic [3:0] a, input logic [7:0] d);
    fetch_req = 1'b1;
    pc        = a;
    push_exp(d, 1'b0);
    @(posedge clk); #1;
    fetch_req = 1'b0;
    chk("hit_no_req", 32'(imem_req), 32'd0);
    chk("hit_done_t1", 32'(fetch_done), 32'd1);
    wait_idle();
  endtask

  initial begin
    reset      = 1'b0;
    fetch_req  = 1'b0;
    pc         = 4'd0;
    flush      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_next_instr", 32'(next_instr), 32'd0);
    chk("rst_done", 32'(fetch_done), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Cold miss, then hit, then a different address misses
    mem_fetch(4'd4, 3, 8'hA5, 0, 0);
    hit_fetch(4'd4, 8'hA5);
    mem_fetch(4'd5, 1, 8'h5B, 0, 0);

    // Timeout: next_instr keeps 5B, error flag held until the next accepted request
    mem_fetch(4'd7, 0, 8'h5B, 0, 0);
    chk("err_held", 32'(fetch_err), 32'd1);
    chk("instr_held", 32'(next_instr), 32'h5B);
    hit_fetch(4'd5, 8'h5B);
    chk("err_cleared", 32'(fetch_err), 32'd0);

    // Flush during the memory wait: data delivered, buffer stays invalid
    mem_fetch(4'd4, 4, 8'h3C, 2, 0);
    mem_fetch(4'd4, 2, 8'h3D, 0, 0);
    hit_fetch(4'd4, 8'h3D);

    // Request pulsed while busy is ignored; ack on the final allowed cycle wins
    mem_fetch(4'd9, TIMEOUT, 8'h77, 0, 5);

    // Asynchronous reset in the middle of a memory access
    fetch_req = 1'b1;
    pc        = 4'd12;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_instr", 32'(next_instr), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    imem_ack   = 1'b1;
    imem_rdata = 8'hEE;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    chk("late_ack_busy", 32'(busy), 32'd0);
    chk("late_ack_instr", 32'(next_instr), 32'd0);
    // pc 9 was buffered before the reset; it must miss now
    mem_fetch(4'd9, 2, 8'hC1, 0, 0);

    // Address wrap is an ordinary address
    mem_fetch(4'd15, 1, 8'hF0, 0, 0);
    mem_fetch(4'd0, 1, 8'h0F, 0, 0);
    hit_fetch(4'd0, 8'h0F);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Supplies the 8-bit instruction word that the data path latches into its instruction register on `ir_write`.
- Sits between the control unit, the data path PC and a variable-latency instruction memory.
- On a fetch request it returns the instruction at the current PC, either from a one-entry last-fetch buffer or from instruction memory via a req/ack handshake.
- Bounds every memory access with a timeout.

Parameters:
- ADDR_WIDTH, 4, width of PC / instruction memory address.
- INSTR_WIDTH, 8, instruction word width (matches `instruction_t`).
- TIMEOUT, 15, max cycles `imem_req` stays high without `imem_ack` before abort; legal range 1..255.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- fetch_req  input  1  fetch start; sampled only in IDLE.
- pc  input  ADDR_WIDTH  address to fetch; sampled with `fetch_req`.
- flush  input  1  invalidate last-fetch buffer.
- next_instr  output  INSTR_WIDTH  fetched instruction, held stable until the next successful fetch.
- fetch_done  output  1  one-cycle pulse, fetch finished (success or error).
- fetch_err  output  1  high with `fetch_done` on timeout; held until next accepted `fetch_req`.
- busy  output  1  high in any state other than IDLE.
- imem_req  output  1  instruction memory request, held until ack or timeout.
- imem_addr  output  ADDR_WIDTH  latched PC, stable while `imem_req` is high.
- imem_ack  input  1  memory data valid; ignored unless `imem_req` is high.
- imem_rdata  input  INSTR_WIDTH  memory read data, valid when `imem_ack` is high.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; `next_instr`=0; `fetch_done`=0; `fetch_err`=0; `busy`=0; `imem_req`=0; `imem_addr`=0.
  - Buffer valid=0, tag=0, data=0; timeout counter=0; `flush_pending`=0.
  - Reset mid-fetch drops `imem_req` immediately. Any late `imem_ack` after reset release is ignored.
- FSM states: IDLE, HIT, MEM, DONE, ERR.
- IDLE, `fetch_req`=1 at edge t:
  - Latch `pc` into `imem_addr`.
  - `fetch_err` cleared.
  - If buffer valid, tag==`pc` and `flush`=0: go to HIT. Otherwise go to MEM with counter=0.
- HIT: `next_instr`<=buffer data; `fetch_done`=1 in this cycle; return to IDLE. Hit latency is 1 cycle after the request edge.
- MEM:
  - `imem_req`=1 (registered, first high the cycle after the request edge).
  - Each cycle with `imem_ack`=0, the counter increments.
  - `imem_ack`=1 at edge k: `next_instr`<=`imem_rdata`; buffer tag<=`imem_addr`; buffer data<=`imem_rdata`. Buffer valid<=1 unless `flush_pending` or `flush`. Go to DONE; `imem_req` is low from k onward.
  - Counter reaching TIMEOUT with no ack: go to ERR; `imem_req` drops.
  - Ack on the same edge the counter would reach TIMEOUT: the ack wins (success).
- DONE: `fetch_done`=1 for one cycle, `fetch_err`=0; return to IDLE.
- ERR:
  - `fetch_done`=1 and `fetch_err`=1 for one cycle; `next_instr` and the buffer are unchanged.
  - Return to IDLE; `fetch_err` stays 1 until the next accepted `fetch_req`.
- `fetch_req` while `busy`=1 is ignored (not queued). The control unit must wait for `fetch_done`.
- `fetch_req` on the same cycle as `fetch_done` is ignored. The next request is accepted from IDLE on the following cycle.
- flush:
  - Clears buffer valid on the next edge in any state.
  - flush during MEM sets `flush_pending`, so the in-flight ack delivers `next_instr` but leaves the buffer invalid.
  - `flush_pending` clears on return to IDLE.
  - flush together with `fetch_req` in IDLE forces the MEM path.
- `pc` wrap: address 15 then 0 is treated as an ordinary address; no arithmetic is performed on `pc`.
- `next_instr` changes only on a HIT or a MEM ack; `fetch_done` is never high for two consecutive cycles.

Test Plan:
- Reset release, `fetch_req` with `pc`=4, memory acks 3 cycles after `imem_req` with 8'hA5 -> `imem_addr`=4, `imem_req` high 3 cycles, `fetch_done` 1 cycle later, `next_instr`=8'hA5, `fetch_err`=0.
- Repeat `fetch_req` with `pc`=4 -> no `imem_req`, `fetch_done` at t+1, `next_instr`=8'hA5. Then `pc`=5 -> miss, new memory access.
- `pc`=7, memory never acks, TIMEOUT=15 -> `imem_req` high exactly 15 cycles, then `fetch_done`=1 and `fetch_err`=1, `next_instr` unchanged. Next `fetch_req` clears `fetch_err`.
- `flush` asserted during the MEM wait for `pc`=4 (ack data 8'h3C) -> `next_instr`=8'h3C; an immediate refetch of `pc`=4 goes to memory (miss).
- `fetch_req` pulsed while busy, plus an ack on the exact TIMEOUT cycle -> second request ignored; fetch completes successfully with `fetch_err`=0.
- reset=0 asserted mid-MEM -> `imem_req`, `busy` and `next_instr` go to 0 asynchronously. After release, a first fetch of the previous `pc` misses.
